// File: rtl/retx_backoff_timer.sv
// retx_backoff_timer
// Retransmission timeout engine for the SiTCP TCP path. START arms a down-counter
// loaded with max(BASE_MS,1) << shift. The counter is decremented by the 1 ms tick
// from the interval-pulse generator. When it expires, the block pulses TIMEOUT and
// raises the backoff exponent, so the next interval is twice as long. After
// MAX_RETRY consecutive timeouts the block raises GIVEUP. ACK clears the backoff.
//
// Optional build macro: COARSE_TICK_EN
//   When defined, the block gains the TICK_100MS and COARSE ports. COARSE is latched
//   at each arm, and when latched high the 100 ms tick drives the count. When the
//   macro is undefined, only TICK_1MS is used.

module retx_backoff_timer #(
  parameter int CNT_W     = 24,
  parameter int MAX_SHIFT = 6,
  parameter int MAX_RETRY = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK_1MS,
`ifdef COARSE_TICK_EN
  input  logic             TICK_100MS,
  input  logic             COARSE,
`endif
  input  logic [15:0]      BASE_MS,
  input  logic             START,
  input  logic             STOP,
  input  logic             ACK,
  output logic             TIMEOUT,
  output logic             BUSY,
  output logic             GIVEUP,
  output logic [3:0]       RETRY_CNT,
  output logic [CNT_W-1:0] REMAIN
);

  // The shift register must hold the values 0..MAX_SHIFT.
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 2);
  // The load is computed wide enough that the shift can never lose bits before the
  // saturation check.
  localparam int WIDE_W  = ((CNT_W > 16) ? CNT_W : 16) + MAX_SHIFT + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [SHIFT_W-1:0] shift, shift_nxt;
  logic [3:0]         retry, retry_nxt;
  logic               giveup, giveup_nxt;
  logic               timeout_q, timeout_nxt;
  logic               busy_q;
  logic               tick_sel;
`ifdef COARSE_TICK_EN
  logic               coarse_q, coarse_nxt;
`endif

  // A BASE_MS of zero behaves as one. The shifted value clamps to all-ones when it
  // does not fit in the counter.
  function automatic logic [CNT_W-1:0] calc_load(input logic [15:0]        base,
                                                 input logic [SHIFT_W-1:0] sh);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'((base == 16'd0) ? 16'd1 : base) << sh;
    if (|wide[WIDE_W-1:CNT_W])
      calc_load = {CNT_W{1'b1}};
    else
      calc_load = wide[CNT_W-1:0];
  endfunction

`ifdef COARSE_TICK_EN
  assign tick_sel = coarse_q ? TICK_100MS : TICK_1MS;
`else
  assign tick_sel = TICK_1MS;
`endif

  // Next-state logic. The priority order is ACK > STOP > expiry > START. An
  // expiry is handled before START, so a START in the same cycle re-arms with the
  // shift value the expiry has just raised.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    shift_nxt   = shift;
    retry_nxt   = retry;
    giveup_nxt  = giveup;
    timeout_nxt = 1'b0;
`ifdef COARSE_TICK_EN
    coarse_nxt  = coarse_q;
`endif
    if (ACK) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      shift_nxt  = '0;
      retry_nxt  = 4'd0;
      giveup_nxt = 1'b0;
    end else if (STOP) begin
      if (state == RUN) begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    end else begin
      if (state == RUN && tick_sel) begin
        if (count > CNT_W'(1)) begin
          count_nxt = count - CNT_W'(1);
        end else if (count == CNT_W'(1)) begin
          state_nxt   = IDLE;
          count_nxt   = '0;
          timeout_nxt = 1'b1;
          if (retry != 4'd15)
            retry_nxt = retry + 4'd1;
          if (shift < SHIFT_W'(MAX_SHIFT))
            shift_nxt = shift + SHIFT_W'(1);
          if (retry_nxt == 4'(MAX_RETRY))
            giveup_nxt = 1'b1;
        end
      end
      if (START && !giveup_nxt) begin
        state_nxt = RUN;
        count_nxt = calc_load(BASE_MS, shift_nxt);
`ifdef COARSE_TICK_EN
        coarse_nxt = COARSE;
`endif
      end
    end
  end

  // State and output registers, with a synchronous reset that aborts any count in
  // progress without producing a TIMEOUT pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      count     <= '0;
      shift     <= '0;
      retry     <= 4'd0;
      giveup    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef COARSE_TICK_EN
      coarse_q  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      shift     <= shift_nxt;
      retry     <= retry_nxt;
      giveup    <= giveup_nxt;
      timeout_q <= timeout_nxt;
      busy_q    <= (state_nxt == RUN);
`ifdef COARSE_TICK_EN
      coarse_q  <= coarse_nxt;
`endif
    end
  end

  assign TIMEOUT   = timeout_q;
  assign BUSY      = busy_q;
  assign GIVEUP    = giveup;
  assign RETRY_CNT = retry;
  assign REMAIN    = count;

endmodule

// File: tb/tb_retx_backoff_timer.sv
// Testbench for retx_backoff_timer. Three instances share a single stimulus stream:
//   a: CNT_W=20, MAX_SHIFT=6, MAX_RETRY=8 (saturation and basic behaviour)
//   b: CNT_W=24, MAX_SHIFT=2, MAX_RETRY=8 (backoff ceiling)
//   c: CNT_W=24, MAX_SHIFT=6, MAX_RETRY=2 (give-up)
// A behavioural model, based on the timer's rules, predicts every output.
// Stimulus is driven on the falling edge and the outputs are sampled on the next
// falling edge.

module tb_retx_backoff_timer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        TICK_1MS = 1'b0;
  logic        TICK_100MS = 1'b0;
  logic        COARSE = 1'b0;
  logic [15:0] BASE_MS = 16'd0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        ACK = 1'b0;

  logic        timeout_a, busy_a, giveup_a;
  logic        timeout_b, busy_b, giveup_b;
  logic        timeout_c, busy_c, giveup_c;
  logic [3:0]  retry_a, retry_b, retry_c;
  logic [19:0] remain_a;
  logic [23:0] remain_b, remain_c;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  retx_backoff_timer #(.CNT_W(20), .MAX_SHIFT(6), .MAX_RETRY(8)) dut_a (
    .CLK(CLK), .RST(RST), .TICK_1MS(TICK_1MS),
`ifdef COARSE_TICK_EN
    .TICK_100MS(TICK_100MS), .COARSE(COARSE),
`endif
    .BASE_MS(BASE_MS), .START(START), .STOP(STOP), .ACK(ACK),
    .TIMEOUT(timeout_a), .BUSY(busy_a), .GIVEUP(giveup_a),
    .RETRY_CNT(retry_a), .REMAIN(remain_a)
  );

  retx_backoff_timer #(.CNT_W(24), .MAX_SHIFT(2), .MAX_RETRY(8)) dut_b (
    .CLK(CLK), .RST(RST), .TICK_1MS(TICK_1MS),
`ifdef COARSE_TICK_EN
    .TICK_100MS(TICK_100MS), .COARSE(COARSE),
`endif
    .BASE_MS(BASE_MS), .START(START), .STOP(STOP), .ACK(ACK),
    .TIMEOUT(timeout_b), .BUSY(busy_b), .GIVEUP(giveup_b),
    .RETRY_CNT(retry_b), .REMAIN(remain_b)
  );

  retx_backoff_timer #(.CNT_W(24), .MAX_SHIFT(6), .MAX_RETRY(2)) dut_c (
    .CLK(CLK), .RST(RST), .TICK_1MS(TICK_1MS),
`ifdef COARSE_TICK_EN
    .TICK_100MS(TICK_100MS), .COARSE(COARSE),
`endif
    .BASE_MS(BASE_MS), .START(START), .STOP(STOP), .ACK(ACK),
    .TIMEOUT(timeout_c), .BUSY(busy_c), .GIVEUP(giveup_c),
    .RETRY_CNT(retry_c), .REMAIN(remain_c)
  );

  // Instance parameters as the model sees them.
  function automatic int p_cw(input int i);
    return (i == 0) ? 20 : 24;
  endfunction
  function automatic int p_ms(input int i);
    return (i == 1) ? 2 : 6;
  endfunction
  function automatic int p_mr(input int i);
    return (i == 2) ? 2 : 8;
  endfunction

  // Behavioural model state, one entry per instance.
  bit     m_run[3];
  longint m_count[3];
  int     m_shift[3];
  int     m_retry[3];
  bit     m_giveup[3];
  bit     m_tmo[3];
  bit     m_coarse[3];

  task automatic model_step(input bit rst, input bit ack, input bit stop, input bit start,
                            input bit t1, input bit t100, input bit crs,
                            input logic [15:0] base);
    bit     tk;
    longint ld;
    longint lim;
    for (int i = 0; i < 3; i++) begin
      m_tmo[i] = 1'b0;
      if (rst || ack) begin
        m_run[i] = 1'b0; m_count[i] = 0; m_shift[i] = 0;
        m_retry[i] = 0; m_giveup[i] = 1'b0;
        if (rst) m_coarse[i] = 1'b0;
      end else if (stop) begin
        m_run[i] = 1'b0; m_count[i] = 0;
      end else begin
`ifdef COARSE_TICK_EN
        tk = m_coarse[i] ? t100 : t1;
`else
        tk = t1 | (t100 & 1'b0);
`endif
        if (m_run[i] && tk) begin
          if (m_count[i] == 1) begin
            m_run[i] = 1'b0; m_count[i] = 0; m_tmo[i] = 1'b1;
            if (m_retry[i] < 15) m_retry[i] = m_retry[i] + 1;
            if (m_shift[i] < p_ms(i)) m_shift[i] = m_shift[i] + 1;
            if (m_retry[i] == p_mr(i)) m_giveup[i] = 1'b1;
          end else begin
            m_count[i] = m_count[i] - 1;
          end
        end
        if (start && !m_giveup[i]) begin
          ld  = (base == 16'd0) ? 64'd1 : longint'(base);
          ld  = ld * (longint'(1) << m_shift[i]);
          lim = (longint'(1) << p_cw(i)) - 1;
          m_count[i]  = (ld > lim) ? lim : ld;
          m_run[i]    = 1'b1;
          m_coarse[i] = crs;
        end
      end
    end
  endtask

  function automatic logic [30:0] exp_vec(input int i);
    return {m_tmo[i], m_run[i], m_giveup[i], 4'(m_retry[i]), 24'(m_count[i])};
  endfunction

  function automatic logic [30:0] obs_vec(input int i);
    case (i)
      0:       return {timeout_a, busy_a, giveup_a, retry_a, 4'd0, remain_a};
      1:       return {timeout_b, busy_b, giveup_b, retry_b, remain_b};
      default: return {timeout_c, busy_c, giveup_c, retry_c, remain_c};
    endcase
  endfunction

  task automatic drive_cycle(input bit rst, input bit ack, input bit stop, input bit start,
                             input bit t1, input bit t100, input bit crs,
                             input logic [15:0] base);
    RST = rst; ACK = ack; STOP = stop; START = start;
    TICK_1MS = t1; TICK_100MS = t100; COARSE = crs; BASE_MS = base;
    @(posedge CLK);
    model_step(rst, ack, stop, start, t1, t100, crs, base);
    @(negedge CLK);
    RST = 1'b0; ACK = 1'b0; STOP = 1'b0; START = 1'b0;
    TICK_1MS = 1'b0; TICK_100MS = 1'b0; COARSE = 1'b0;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask
  task automatic tick_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask
  task automatic start_cycle(input logic [15:0] base);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, base);
  endtask
  task automatic ack_cycle();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== 31'd0) begin
        bad++;
        $display("[TB] FAIL reset_state inst%0d got=%h want=%h", i, obs_vec(i), 31'd0);
      end
    end
  endtask

  task automatic test_basic_expiry();
    ack_cycle();
    start_cycle(16'd3);
    tick_cycle(); idle_cycle(); tick_cycle(); idle_cycle();
    total++;
    if (remain_a !== 20'd1 || busy_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_before_expiry remain=%0d busy=%b want remain=1 busy=1", remain_a, busy_a);
    end
    tick_cycle();
    total++;
    if ({timeout_a, busy_a, retry_a, remain_a} !== {1'b1, 1'b0, 4'd1, 20'd0}) begin
      bad++;
      $display("[TB] FAIL basic_expiry to=%b busy=%b retry=%0d remain=%0d want to=1 busy=0 retry=1 remain=0",
               timeout_a, busy_a, retry_a, remain_a);
    end
    idle_cycle();
    total++;
    if (timeout_a !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_pulse_width got=%b want=0", timeout_a);
    end
  endtask

  task automatic test_backoff();
    int n;
    int exp_n[4] = '{5, 10, 20, 20};
    ack_cycle();
    for (int k = 0; k < 4; k++) begin
      start_cycle(16'd5);
      n = 0;
      do begin
        tick_cycle();
        n++;
      end while (timeout_b !== 1'b1 && n < 100);
      total++;
      if (n != exp_n[k]) begin
        bad++;
        $display("[TB] FAIL backoff_round%0d ticks got=%0d want=%0d", k, n, exp_n[k]);
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i)) begin
          bad++;
          $display("[TB] FAIL backoff_model inst%0d got=%h want=%h", i, obs_vec(i), exp_vec(i));
        end
      end
    end
    total++;
    if (retry_b !== 4'd4) begin
      bad++;
      $display("[TB] FAIL backoff_retry got=%0d want=4", retry_b);
    end
  endtask

  task automatic test_giveup();
    int n;
    ack_cycle();
    for (int k = 0; k < 2; k++) begin
      start_cycle(16'd1);
      n = 0;
      do begin
        tick_cycle();
        n++;
      end while (timeout_c !== 1'b1 && n < 50);
      total++;
      if (n != k + 1) begin
        bad++;
        $display("[TB] FAIL giveup_round%0d ticks got=%0d want=%0d", k, n, k + 1);
      end
    end
    total++;
    if (giveup_c !== 1'b1) begin
      bad++;
      $display("[TB] FAIL giveup_set got=%b want=1", giveup_c);
    end
    start_cycle(16'd1);
    total++;
    if (busy_c !== 1'b0) begin
      bad++;
      $display("[TB] FAIL giveup_blocks_start busy got=%b want=0", busy_c);
    end
    ack_cycle();
    total++;
    if (giveup_c !== 1'b0 || retry_c !== 4'd0) begin
      bad++;
      $display("[TB] FAIL giveup_ack giveup=%b retry=%0d want 0 0", giveup_c, retry_c);
    end
    start_cycle(16'd1);
    total++;
    if (busy_c !== 1'b1 || remain_c !== 24'd1) begin
      bad++;
      $display("[TB] FAIL giveup_rearm busy=%b remain=%0d want busy=1 remain=1", busy_c, remain_c);
    end
  endtask

  task automatic test_simultaneous();
    ack_cycle();
    start_cycle(16'd4);
    tick_cycle(); tick_cycle(); tick_cycle();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    total++;
    if ({timeout_a, busy_a, retry_a} !== {1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("[TB] FAIL ack_on_expiry to=%b busy=%b retry=%0d want 0 0 0", timeout_a, busy_a, retry_a);
    end
    ack_cycle();
    start_cycle(16'd4);
    tick_cycle(); tick_cycle(); tick_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);
    total++;
    if ({timeout_a, busy_a, retry_a, remain_a} !== {1'b1, 1'b1, 4'd1, 20'd8}) begin
      bad++;
      $display("[TB] FAIL start_on_expiry to=%b busy=%b retry=%0d remain=%0d want 1 1 1 8",
               timeout_a, busy_a, retry_a, remain_a);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== exp_vec(i)) begin
        bad++;
        $display("[TB] FAIL simultaneous_model inst%0d got=%h want=%h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_boundary();
    int n;
    ack_cycle();
    start_cycle(16'd10);
    tick_cycle(); tick_cycle(); tick_cycle();
    total++;
    if (remain_a !== 20'd7) begin
      bad++;
      $display("[TB] FAIL pre_reset_remain got=%0d want=7", remain_a);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== 31'd0) begin
        bad++;
        $display("[TB] FAIL reset_mid_count inst%0d got=%h want=%h", i, obs_vec(i), 31'd0);
      end
    end
    idle_cycle();
    total++;
    if (timeout_a !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_no_timeout got=%b want=0", timeout_a);
    end
    ack_cycle();
    start_cycle(16'd0);
    tick_cycle();
    total++;
    if (timeout_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL base_zero_expiry got=%b want=1", timeout_a);
    end
    ack_cycle();
    for (int k = 0; k < 6; k++) begin
      start_cycle(16'd1);
      n = 0;
      do begin
        tick_cycle();
        n++;
      end while (timeout_a !== 1'b1 && n < 100);
    end
    start_cycle(16'hFFFF);
    total++;
    if (remain_a !== 20'hFFFFF || retry_a !== 4'd6) begin
      bad++;
      $display("[TB] FAIL saturate remain=%h retry=%0d want remain=fffff retry=6", remain_a, retry_a);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== exp_vec(i)) begin
        bad++;
        $display("[TB] FAIL boundary_model inst%0d got=%h want=%h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

`ifdef COARSE_TICK_EN
  task automatic test_coarse();
    ack_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
    tick_cycle(); tick_cycle(); tick_cycle();
    total++;
    if (busy_a !== 1'b1 || remain_a !== 20'd2) begin
      bad++;
      $display("[TB] FAIL coarse_ignores_1ms busy=%b remain=%0d want 1 2", busy_a, remain_a);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    total++;
    if (timeout_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL coarse_expiry got=%b want=1", timeout_a);
    end
  endtask
`endif

  task automatic test_random();
    bit          rst, ack, stop, start, t1, t100, crs;
    logic [15:0] base;
    int          r;
    ack_cycle();
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 99) < 2);
      ack   = ($urandom_range(0, 99) < 3);
      stop  = ($urandom_range(0, 99) < 4);
      start = ($urandom_range(0, 99) < 15);
      t1    = ($urandom_range(0, 99) < 50);
      t100  = ($urandom_range(0, 99) < 30);
      crs   = ($urandom_range(0, 99) < 50);
      r     = $urandom_range(0, 15);
      if (r < 13)       base = 16'($urandom_range(0, 6));
      else if (r == 13) base = 16'hFFFF;
      else              base = 16'($urandom_range(0, 65535));
      drive_cycle(rst, ack, stop, start, t1, t100, crs, base);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i)) begin
          bad++;
          $display("[TB] FAIL random_c%0d inst%0d got=%h want=%h", c, i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic_expiry();
    test_backoff();
    test_giveup();
    test_simultaneous();
    test_boundary();
`ifdef COARSE_TICK_EN
    test_coarse();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
